// File: rtl/fifo_word_serializer_if.sv
// Bundle between the serializer, the fsfifo read port and the downstream slice stream.
// master = serializer side, slave = FIFO/stream-partner side.
interface fifo_word_serializer_if #(
    parameter int WIDTH     = 32,
    parameter int OUT_WIDTH = 8
);
    logic                 fifo_empty_i;
    logic                 fifo_rd_o;
    logic [WIDTH-1:0]     fifo_data_i;
    logic                 m_valid_o;
    logic                 m_ready_i;
    logic [OUT_WIDTH-1:0] m_data_o;
    logic                 m_last_o;

    modport master (
        input  fifo_empty_i, fifo_data_i, m_ready_i,
        output fifo_rd_o, m_valid_o, m_data_o, m_last_o
    );

    modport slave (
        output fifo_empty_i, fifo_data_i, m_ready_i,
        input  fifo_rd_o, m_valid_o, m_data_o, m_last_o
    );
endinterface

// File: rtl/fifo_word_serializer.sv
// Drains WIDTH-bit words from an fsfifo read port and streams them as OUT_WIDTH-bit slices.
// A one-word prefetch register hides the FIFO's one-cycle read latency.
module fifo_word_serializer #(
    parameter int WIDTH     = 32,
    parameter int OUT_WIDTH = 8,
    parameter bit MSB_FIRST = 1'b0
) (
    input  logic                   clk_i,
    input  logic                   reset_ni,
    input  logic                   flush_i,
    fifo_word_serializer_if.master bus,
    output logic                   busy_o
);
    localparam int N  = WIDTH / OUT_WIDTH;
    localparam int CW = (N > 1) ? $clog2(N) : 1;
    localparam logic [CW-1:0] LAST_CNT = CW'(N - 1);

    generate
        if (((WIDTH % OUT_WIDTH) != 0) || (OUT_WIDTH > WIDTH)) begin : g_bad_width
            $error("fifo_word_serializer: WIDTH must be a positive multiple of OUT_WIDTH");
        end
    endgenerate

    function automatic logic [OUT_WIDTH-1:0] slice_of(input logic [WIDTH-1:0] word,
                                                      input logic [CW-1:0]    cnt);
        logic [CW-1:0] idx;
        if (MSB_FIRST) begin
            idx = LAST_CNT - cnt;
        end else begin
            idx = cnt;
        end
        return word[int'(idx) * OUT_WIDTH +: OUT_WIDTH];
    endfunction

    logic [WIDTH-1:0]     w_r, w_s, p_r, p_s;
    logic [CW-1:0]        cnt_r, cnt_s;
    logic                 wv_r, wv_s, pv_r, pv_s, pend_r;
    logic [OUT_WIDTH-1:0] m_data_r, m_data_s;
    logic                 m_last_r, m_last_s;
    logic [1:0]           occ_s;
    logic                 rd_s, accept_s, retire_s, w_free_s;

    // Read request: reset also gates it so fifo_rd_o is low for the whole reset window.
    always_comb begin
        occ_s    = {1'b0, wv_r} + {1'b0, pv_r} + {1'b0, pend_r};
        rd_s     = reset_ni && !bus.fifo_empty_i && !flush_i && (occ_s < 2'd2);
        accept_s = wv_r && bus.m_ready_i;
        retire_s = accept_s && (cnt_r == LAST_CNT);
        w_free_s = !wv_r || retire_s;
    end

    // Next state: the prefetched word refills W before freshly returned FIFO data.
    always_comb begin
        w_s   = w_r;
        p_s   = p_r;
        cnt_s = cnt_r;
        wv_s  = wv_r;
        pv_s  = pv_r;
        if (flush_i) begin
            wv_s  = 1'b0;
            pv_s  = 1'b0;
            cnt_s = {CW{1'b0}};
        end else if (w_free_s) begin
            if (pv_r) begin
                w_s   = p_r;
                wv_s  = 1'b1;
                cnt_s = {CW{1'b0}};
                pv_s  = pend_r;
                if (pend_r) begin
                    p_s = bus.fifo_data_i;
                end else begin
                    p_s = p_r;
                end
            end else if (pend_r) begin
                w_s   = bus.fifo_data_i;
                wv_s  = 1'b1;
                cnt_s = {CW{1'b0}};
            end else begin
                wv_s  = 1'b0;
                cnt_s = {CW{1'b0}};
            end
        end else begin
            if (accept_s) begin
                cnt_s = cnt_r + CW'(1);
            end else begin
                cnt_s = cnt_r;
            end
            if (pend_r) begin
                p_s  = bus.fifo_data_i;
                pv_s = 1'b1;
            end else begin
                pv_s = pv_r;
            end
        end
        m_data_s = slice_of(w_s, cnt_s);
        m_last_s = wv_s && (cnt_s == LAST_CNT);
    end

    // State and output registers; the slice is registered from next-state W/cnt.
    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            w_r      <= {WIDTH{1'b0}};
            p_r      <= {WIDTH{1'b0}};
            cnt_r    <= {CW{1'b0}};
            wv_r     <= 1'b0;
            pv_r     <= 1'b0;
            pend_r   <= 1'b0;
            m_data_r <= {OUT_WIDTH{1'b0}};
            m_last_r <= 1'b0;
        end else begin
            w_r      <= w_s;
            p_r      <= p_s;
            cnt_r    <= cnt_s;
            wv_r     <= wv_s;
            pv_r     <= pv_s;
            pend_r   <= rd_s;
            m_data_r <= m_data_s;
            m_last_r <= m_last_s;
        end
    end

    assign bus.fifo_rd_o = rd_s;
    assign bus.m_valid_o = wv_r;
    assign bus.m_data_o  = m_data_r;
    assign bus.m_last_o  = m_last_r;
    assign busy_o        = wv_r || pv_r || pend_r;

endmodule

// File: tb/tb_fifo_word_serializer.sv
// Scoreboard bench for fifo_word_serializer: one LSB-first and one MSB-first instance,
// each fed by a small fsfifo model with one-cycle read latency.
module tb_fifo_word_serializer;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic reset_ni;
    logic flush;
    logic busy_a, busy_b;

    fifo_word_serializer_if #(.WIDTH(32), .OUT_WIDTH(8)) bus_a ();
    fifo_word_serializer_if #(.WIDTH(32), .OUT_WIDTH(8)) bus_b ();

    fifo_word_serializer #(.WIDTH(32), .OUT_WIDTH(8), .MSB_FIRST(1'b0)) u_dut_a (
        .clk_i(clk), .reset_ni(reset_ni), .flush_i(flush), .bus(bus_a), .busy_o(busy_a)
    );
    fifo_word_serializer #(.WIDTH(32), .OUT_WIDTH(8), .MSB_FIRST(1'b1)) u_dut_b (
        .clk_i(clk), .reset_ni(reset_ni), .flush_i(flush), .bus(bus_b), .busy_o(busy_b)
    );

    // fsfifo models: stimulus owns the push side, the model owns the pop side
    logic [31:0] mem_a[$];
    logic [31:0] mem_b[$];
    int push_a_cnt = 0, pop_a_cnt = 0, push_b_cnt = 0, pop_b_cnt = 0;

    assign bus_a.fifo_empty_i = (push_a_cnt == pop_a_cnt);
    assign bus_b.fifo_empty_i = (push_b_cnt == pop_b_cnt);

    always @(posedge clk) begin
        if (bus_a.fifo_rd_o) begin
            bus_a.fifo_data_i <= mem_a[pop_a_cnt];
            pop_a_cnt <= pop_a_cnt + 1;
        end
        if (bus_b.fifo_rd_o) begin
            bus_b.fifo_data_i <= mem_b[pop_b_cnt];
            pop_b_cnt <= pop_b_cnt + 1;
        end
    end

    // scoreboard queues: {last, data}
    logic [8:0]  exp_a[$];
    logic [8:0]  exp_b[$];
    string       probe_name[$];
    logic [11:0] probe_exp[$];
    logic [11:0] probe_mask[$];

    int timeouts   = 0;
    int run_expect = 0;
    bit done       = 1'b0;

    int errors = 0, checks = 0;
    int cyc = 0, rd_words = 0, done_words = 0, lat_cyc = 0, run = 0;
    bit lat_pending = 1'b0, prev_valid = 1'b0;
    logic [8:0]  e9;
    logic [11:0] act, pe, pm;
    string       pn;

    // monitor: the only process that counts checks and errors
    always @(negedge clk) begin
        cyc++;
        if (probe_name.size() > 0) begin
            pn  = probe_name.pop_front();
            pe  = probe_exp.pop_front();
            pm  = probe_mask.pop_front();
            act = {bus_a.m_valid_o, bus_a.m_last_o, bus_a.fifo_rd_o, busy_a, bus_a.m_data_o};
            checks++;
            if ((act & pm) !== (pe & pm)) begin
                errors++;
                $display("FAIL %s: got valid/last/rd/busy/data=%h want %h (mask %h)", pn, act, pe, pm);
            end
        end
        if (!reset_ni) begin
            exp_a.delete();
            exp_b.delete();
            done_words  = rd_words;
            lat_pending = 1'b0;
            prev_valid  = 1'b0;
            run         = 0;
        end else if (flush) begin
            done_words  = rd_words;
            lat_pending = 1'b0;
        end else begin
            if (bus_a.fifo_rd_o) begin
                checks++;
                if (bus_a.fifo_empty_i !== 1'b0) begin
                    errors++;
                    $display("FAIL rd_when_empty: got empty=%b with rd=1, want empty=0", bus_a.fifo_empty_i);
                end
                checks++;
                if (rd_words - done_words >= 2) begin
                    errors++;
                    $display("FAIL over_read: got %0d words held before read, want <2", rd_words - done_words);
                end
                if (!busy_a && !bus_a.m_valid_o) begin
                    lat_pending = 1'b1;
                    lat_cyc     = cyc;
                end
                rd_words++;
            end
            if (bus_a.m_valid_o && bus_a.m_ready_i) begin
                checks++;
                if (exp_a.size() == 0) begin
                    errors++;
                    $display("FAIL slice_a: got last=%b data=%h, want no slice", bus_a.m_last_o, bus_a.m_data_o);
                end else begin
                    e9 = exp_a.pop_front();
                    if ({bus_a.m_last_o, bus_a.m_data_o} !== e9) begin
                        errors++;
                        $display("FAIL slice_a: got last=%b data=%h want last=%b data=%h",
                                 bus_a.m_last_o, bus_a.m_data_o, e9[8], e9[7:0]);
                    end
                end
                if (bus_a.m_last_o) done_words++;
            end
            if (bus_a.m_valid_o && !prev_valid && lat_pending) begin
                checks++;
                lat_pending = 1'b0;
                if (cyc - lat_cyc != 2) begin
                    errors++;
                    $display("FAIL latency: got %0d cycles rd->valid, want 2", cyc - lat_cyc);
                end
            end
            if (bus_a.m_valid_o) begin
                run++;
            end else begin
                if (prev_valid && run_expect != 0) begin
                    checks++;
                    if (run != run_expect) begin
                        errors++;
                        $display("FAIL valid_run: got %0d consecutive valid cycles want %0d", run, run_expect);
                    end
                end
                run = 0;
            end
            prev_valid = bus_a.m_valid_o;
            if (bus_b.m_valid_o && bus_b.m_ready_i) begin
                checks++;
                if (exp_b.size() == 0) begin
                    errors++;
                    $display("FAIL slice_b: got last=%b data=%h, want no slice", bus_b.m_last_o, bus_b.m_data_o);
                end else begin
                    e9 = exp_b.pop_front();
                    if ({bus_b.m_last_o, bus_b.m_data_o} !== e9) begin
                        errors++;
                        $display("FAIL slice_b: got last=%b data=%h want last=%b data=%h",
                                 bus_b.m_last_o, bus_b.m_data_o, e9[8], e9[7:0]);
                    end
                end
            end
        end
        if (done) begin
            checks++;
            if (exp_a.size() != 0 || exp_b.size() != 0) begin
                errors++;
                $display("FAIL drained: got %0d/%0d slices outstanding want 0/0", exp_a.size(), exp_b.size());
            end
            checks++;
            if (timeouts != 0) begin
                errors++;
                $display("FAIL timeouts: got %0d want 0", timeouts);
            end
            $display("Result: errors=%0d of %0d checks", errors, checks);
            $finish;
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push_a(input logic [31:0] w);
        mem_a.push_back(w);
        push_a_cnt++;
    endtask

    task automatic push_b(input logic [31:0] w);
        mem_b.push_back(w);
        push_b_cnt++;
    endtask

    task automatic expect_a(input logic last, input logic [7:0] d);
        exp_a.push_back({last, d});
    endtask

    task automatic expect_b(input logic last, input logic [7:0] d);
        exp_b.push_back({last, d});
    endtask

    task automatic probe(input string name, input logic v, input logic l, input logic r,
                         input logic b, input logic [7:0] d, input logic [11:0] m);
        probe_name.push_back(name);
        probe_exp.push_back({v, l, r, b, d});
        probe_mask.push_back(m);
    endtask

    task automatic wait_valid_a(input int bound);
        int n;
        n = 0;
        while (!bus_a.m_valid_o && n < bound) begin
            step();
            n++;
        end
        if (!bus_a.m_valid_o) begin
            timeouts++;
            $display("FAIL wait_valid: got valid=0 after %0d cycles, want 1", bound);
        end
    endtask

    task automatic wait_drain(input int bound);
        int n;
        n = 0;
        while ((exp_a.size() != 0 || exp_b.size() != 0) && n < bound) begin
            step();
            n++;
        end
        if (exp_a.size() != 0 || exp_b.size() != 0) begin
            timeouts++;
            $display("FAIL wait_drain: got %0d/%0d slices pending after %0d cycles, want 0/0",
                     exp_a.size(), exp_b.size(), bound);
        end
    endtask

    initial begin
        reset_ni = 1'b1;
        flush    = 1'b0;
        bus_a.m_ready_i = 1'b0;
        bus_b.m_ready_i = 1'b1;
        #2 reset_ni = 1'b0;
        step();
        probe("reset_state", 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 12'hFFF);
        step();
        reset_ni = 1'b1;

        // single word, LSB first
        bus_a.m_ready_i = 1'b1;
        expect_a(1'b0, 8'hD4); expect_a(1'b0, 8'hC3); expect_a(1'b0, 8'hB2); expect_a(1'b1, 8'hA1);
        push_a(32'hA1B2C3D4);
        wait_drain(40);
        step(); step();
        probe("idle_after_word", 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 12'hF00);

        // same word, MSB first
        expect_b(1'b0, 8'hA1); expect_b(1'b0, 8'hB2); expect_b(1'b0, 8'hC3); expect_b(1'b1, 8'hD4);
        push_b(32'hA1B2C3D4);
        wait_drain(40);
        step(); step();

        // four words back to back: 16 valid cycles without a bubble
        run_expect = 16;
        for (int i = 0; i < 16; i++) expect_a((i % 4) == 3, 8'(i));
        push_a(32'h03020100); push_a(32'h07060504); push_a(32'h0B0A0908); push_a(32'h0F0E0D0C);
        wait_drain(80);
        step(); step(); step();
        run_expect = 0;

        // backpressure mid-word with W and prefetch full
        bus_a.m_ready_i = 1'b0;
        expect_a(1'b0, 8'h55); expect_a(1'b0, 8'h66); expect_a(1'b0, 8'h77); expect_a(1'b1, 8'h88);
        expect_a(1'b0, 8'h11); expect_a(1'b0, 8'h22); expect_a(1'b0, 8'h33); expect_a(1'b1, 8'h44);
        expect_a(1'b0, 8'h99); expect_a(1'b0, 8'hAA); expect_a(1'b0, 8'hBB); expect_a(1'b1, 8'hCC);
        push_a(32'h88776655); push_a(32'h44332211); push_a(32'hCCBBAA99);
        wait_valid_a(10);
        step();
        probe("prefetch_full", 1'b1, 1'b0, 1'b0, 1'b1, 8'h55, 12'hFFF);
        step();
        bus_a.m_ready_i = 1'b1;
        step();
        bus_a.m_ready_i = 1'b0;
        for (int k = 0; k < 5; k++) begin
            probe("stall_hold", 1'b1, 1'b0, 1'b0, 1'b1, 8'h66, 12'hFFF);
            step();
        end
        bus_a.m_ready_i = 1'b1;
        wait_drain(60);
        step(); step();

        // flush the cycle after the read: DEADBEEF must never appear
        expect_a(1'b0, 8'h8D); expect_a(1'b0, 8'h7C); expect_a(1'b0, 8'h6B); expect_a(1'b1, 8'h5A);
        push_a(32'hDEADBEEF); push_a(32'h5A6B7C8D);
        step();
        flush = 1'b1;
        probe("flush_cycle", 1'b0, 1'b0, 1'b0, 1'b1, 8'h00, 12'hF00);
        step();
        flush = 1'b0;
        probe("after_flush", 1'b0, 1'b0, 1'b1, 1'b0, 8'h00, 12'hF00);
        wait_drain(40);
        step(); step();

        // asynchronous reset mid-word
        bus_a.m_ready_i = 1'b0;
        expect_a(1'b0, 8'hDF); expect_a(1'b0, 8'h9B); expect_a(1'b0, 8'h57); expect_a(1'b1, 8'h13);
        push_a(32'h13579BDF);
        wait_valid_a(10);
        bus_a.m_ready_i = 1'b1;
        step(); step();
        bus_a.m_ready_i = 1'b0;
        #2 reset_ni = 1'b0;
        push_a(32'h2468ACE0);
        probe("async_reset", 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 12'hFFF);
        step();
        reset_ni = 1'b1;
        expect_a(1'b0, 8'hE0); expect_a(1'b0, 8'hAC); expect_a(1'b0, 8'h68); expect_a(1'b1, 8'h24);
        bus_a.m_ready_i = 1'b1;
        wait_drain(40);
        step(); step();
        done = 1'b1;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got no summary after 200000 time units, want finish");
        $fatal(1, "watchdog expired");
    end

endmodule
